// File: rtl/holy_axi_pkg.sv
// Shared AXI encodings and slave FSM states for the SRAM-backed slave.
package holy_axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B     = 3'd2;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_DATA,
        ST_W_RESP,
        ST_R_FETCH,
        ST_R_DATA
    } axi_state_e;

    // A burst never wraps, so checking its first and last beat covers every beat.
    function automatic logic req_err(
        input logic [31:0] addr,
        input logic [7:0]  len,
        input logic [2:0]  size,
        input logic [1:0]  burst,
        input logic [31:0] base,
        input logic [33:0] span
    );
        logic [33:0] first;
        logic [33:0] last;
        first = {2'b00, addr};
        last  = first + {24'd0, len, 2'b00};
        return (burst != AXI_BURST_INCR) || (size != AXI_SIZE_4B) ||
               (addr < base) || (last >= ({2'b00, base} + span));
    endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI4 (no user/cache/prot/lock/qos) channel bundle between a master and the SRAM slave.
interface axi_sram_slave_if;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/sram_1p_bytewe.sv
// Single-port 32-bit SRAM with byte write enables and a registered read port.
module sram_1p_bytewe #(
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Storage is never reset; the read register only updates on a pure read.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave over a single-port SRAM; one burst in flight, writes win AW/AR ties.
module axi_sram_slave
    import holy_axi_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_sram_slave_if.slave     s_axi
);

    localparam int unsigned AW   = $clog2(MEM_WORDS);
    localparam logic [33:0] SPAN = 34'(MEM_WORDS) << 2;

    axi_state_e  state_q, state_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        awready, arready, wready;
    logic        bvalid, rvalid, rlast;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] offset;
    logic        unused_bits;

    assign offset      = addr_q - BASE_ADDR;
    assign unused_bits = ^{offset[31:AW+2], offset[1:0], s_axi.wlast};

    sram_1p_bytewe #(
        .DEPTH (MEM_WORDS)
    ) u_sram (
        .clk_i   (clk),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (offset[AW+1:2]),
        .wdata_i (s_axi.wdata),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        awready = 1'b0;
        arready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        mem_en  = 1'b0;
        mem_we  = 4'b0000;
        unique case (state_q)
            ST_IDLE: begin
                // Ready is gated by rst_n so nothing handshakes while held in reset.
                awready = rst_n;
                arready = rst_n & ~s_axi.awvalid;
                if (s_axi.awvalid) begin
                    state_d = ST_W_DATA;
                    id_d    = s_axi.awid;
                    addr_d  = s_axi.awaddr;
                    len_d   = s_axi.awlen;
                    cnt_d   = '0;
                    err_d   = req_err(s_axi.awaddr, s_axi.awlen, s_axi.awsize,
                                      s_axi.awburst, BASE_ADDR, SPAN);
                end else if (s_axi.arvalid) begin
                    state_d = ST_R_FETCH;
                    id_d    = s_axi.arid;
                    addr_d  = s_axi.araddr;
                    len_d   = s_axi.arlen;
                    cnt_d   = '0;
                    err_d   = req_err(s_axi.araddr, s_axi.arlen, s_axi.arsize,
                                      s_axi.arburst, BASE_ADDR, SPAN);
                end
            end
            ST_W_DATA: begin
                wready = 1'b1;
                if (s_axi.wvalid) begin
                    mem_en = ~err_q;
                    mem_we = err_q ? 4'b0000 : s_axi.wstrb;
                    addr_d = addr_q + 32'd4;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q) begin
                        state_d = ST_W_RESP;
                    end
                end
            end
            ST_W_RESP: begin
                bvalid = 1'b1;
                if (s_axi.bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_R_FETCH: begin
                mem_en  = 1'b1;
                state_d = ST_R_DATA;
            end
            ST_R_DATA: begin
                rvalid = 1'b1;
                rlast  = (cnt_q == len_q);
                if (s_axi.rready) begin
                    if (rlast) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + 32'd4;
                        cnt_d   = cnt_q + 8'd1;
                        state_d = ST_R_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s_axi.awready = awready;
    assign s_axi.arready = arready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bid     = bvalid ? id_q : 4'd0;
    assign s_axi.bresp   = (bvalid && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rlast   = rlast;
    assign s_axi.rid     = rvalid ? id_q : 4'd0;
    assign s_axi.rdata   = (rvalid && !err_q) ? mem_rdata : 32'd0;
    assign s_axi.rresp   = (rvalid && err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave with a word-array reference model.
module tb_axi_sram_slave;

    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] BASE      = 32'h0000_0000;
    localparam longint      LO        = {32'd0, BASE};
    localparam longint      TOP       = LO + 4 * MEM_WORDS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_sram_slave_if bus();

    axi_sram_slave #(
        .MEM_WORDS (MEM_WORDS),
        .BASE_ADDR (BASE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axi (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [MEM_WORDS];
    logic [31:0] wdat [256];
    logic [3:0]  wstb [256];
    logic [5:0]  exp_b [$];
    logic [38:0] exp_r [$];
    logic [31:0] got_d [$];
    logic        got_l [$];
    logic [1:0]  got_p [$];
    time         b_hs_time;
    time         ar_hs_time;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    function automatic bit model_err(input logic [31:0] addr, input int len,
                                     input logic [2:0] size, input logic [1:0] burst);
        longint ba;
        if (burst != 2'b01 || size != 3'd2) return 1'b1;
        for (int i = 0; i <= len; i++) begin
            ba = longint'({32'd0, addr}) + 4 * i;
            if (ba < LO || ba >= TOP) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    // Compare process: every visible B/R beat against the model queues.
    logic        prev_stall = 1'b0;
    logic [38:0] prev_r;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.bvalid) begin
                if (exp_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected bid=%0h bresp=%0h", bus.bid, bus.bresp);
                end else begin
                    chk("b_resp", {bus.bid, bus.bresp}, exp_b[0]);
                    if (bus.bready) void'(exp_b.pop_front());
                end
            end
            if (prev_stall) begin
                chk("r_stable", {bus.rvalid, bus.rid, bus.rdata, bus.rresp, bus.rlast},
                    {1'b1, prev_r});
            end
            if (bus.rvalid) begin
                if (exp_r.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected rid=%0h rdata=%0h", bus.rid, bus.rdata);
                end else begin
                    chk("r_beat", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, exp_r[0]);
                    if (bus.rready) begin
                        void'(exp_r.pop_front());
                        got_d.push_back(bus.rdata);
                        got_l.push_back(bus.rlast);
                        got_p.push_back(bus.rresp);
                    end
                end
            end
            prev_stall = bus.rvalid && !bus.rready;
            prev_r     = {bus.rid, bus.rdata, bus.rresp, bus.rlast};
            if (bus.awvalid && bus.awready) begin
                chk("ar_blocked_by_aw", bus.arready, 0);
            end
        end
    end

    task automatic write_txn(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int abort_at);
        bit          err;
        int          n;
        logic [31:0] a;
        err = model_err(addr, len, size, burst);
        @(posedge clk); #1;
        bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
        bus.awsize = size; bus.awburst = burst; bus.awvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 200);
        if (!bus.awready) begin tmo("aw_wait"); bus.awvalid = 1'b0; return; end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (i == abort_at) return;
            repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
            bus.wdata = wdat[i]; bus.wstrb = wstb[i];
            bus.wlast = (i == len); bus.wvalid = 1'b1;
            n = 0;
            do begin @(negedge clk); n++; end while (!bus.wready && n < 200);
            if (!bus.wready) begin tmo("w_wait"); bus.wvalid = 1'b0; return; end
            @(posedge clk); #1;
            bus.wvalid = 1'b0; bus.wlast = 1'b0;
            if (!err) begin
                a = addr + 32'(4 * i);
                for (int b = 0; b < 4; b++)
                    if (wstb[i][b]) mem_m[widx(a)][8*b +: 8] = wdat[i][8*b +: 8];
            end
        end
        exp_b.push_back({id, err ? 2'b10 : 2'b00});
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.bready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.bvalid && n < 200);
        if (!bus.bvalid) begin tmo("b_wait"); bus.bready = 1'b0; return; end
        @(posedge clk);
        b_hs_time = $time;
        #1;
        bus.bready = 1'b0;
    endtask

    task automatic read_txn(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
        bit          err;
        int          n;
        int          got;
        logic [31:0] a;
        logic [31:0] d;
        err = model_err(addr, len, size, burst);
        @(posedge clk); #1;
        bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
        bus.arsize = size; bus.arburst = burst; bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 400);
        if (!bus.arready) begin tmo("ar_wait"); bus.arvalid = 1'b0; return; end
        @(posedge clk);
        ar_hs_time = $time;
        #1;
        bus.arvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = addr + 32'(4 * i);
            d = err ? 32'd0 : mem_m[widx(a)];
            exp_r.push_back({id, d, err ? 2'b10 : 2'b00, 1'(i == len)});
        end
        got = 0;
        n = 0;
        while (got <= len && n < 2000) begin
            bus.rready = (mode == 0) ? 1'b1 : (mode == 1) ? n[0] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.rvalid && bus.rready) got++;
            @(posedge clk); #1;
            n++;
        end
        bus.rready = 1'b0;
        if (got <= len) tmo("r_beats");
    endtask

    task automatic clear_got();
        got_d.delete();
        got_l.delete();
        got_p.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int          tlen;
    logic [31:0] taddr;
    logic [2:0]  tsize;
    logic [1:0]  tburst;

    initial begin
        bus.awvalid = 0; bus.awid = 0; bus.awaddr = 0; bus.awlen = 0;
        bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0;
        bus.bready = 0;
        bus.arvalid = 0; bus.arid = 0; bus.araddr = 0; bus.arlen = 0;
        bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast,
             bus.bid, bus.rid, bus.bresp, bus.rresp, bus.rdata}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        chk("model_pin_cross", model_err(32'h3FC, 1, 3'd2, 2'b01), 1);
        chk("model_pin_inside", model_err(32'h3FC, 0, 3'd2, 2'b01), 0);

        for (int i = 0; i < 256; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        write_txn(4'h0, 32'h0, 255, 3'd2, 2'b01, -1);

        // Single word round trip
        wdat[0] = 32'hDEAD_BEEF; wstb[0] = 4'hF;
        write_txn(4'h1, 32'h10, 0, 3'd2, 2'b01, -1);
        clear_got();
        read_txn(4'h2, 32'h10, 0, 3'd2, 2'b01, 0);
        chk("single_count", got_d.size(), 1);
        chk("single_data", got_d[0], 32'hDEAD_BEEF);
        chk("single_last", got_l[0], 1);
        chk("single_resp", got_p[0], 0);

        // Eight-beat burst, then the same with rready toggling
        for (int i = 0; i < 8; i++) begin wdat[i] = 32'(i); wstb[i] = 4'hF; end
        write_txn(4'h3, 32'h100, 7, 3'd2, 2'b01, -1);
        clear_got();
        read_txn(4'h5, 32'h100, 7, 3'd2, 2'b01, 0);
        chk("burst_count", got_d.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk("burst_data", got_d[i], 32'(i));
            chk("burst_last", got_l[i], 64'(i == 7));
        end
        clear_got();
        read_txn(4'h5, 32'h100, 7, 3'd2, 2'b01, 1);
        chk("toggle_count", got_d.size(), 8);
        chk("toggle_beat7", got_d[7], 32'd7);

        // Partial strobes
        wdat[0] = 32'hFFFF_FFFF; wstb[0] = 4'hF;
        write_txn(4'h1, 32'h20, 0, 3'd2, 2'b01, -1);
        wdat[0] = 32'h1122_3344; wstb[0] = 4'b0101;
        write_txn(4'h1, 32'h20, 0, 3'd2, 2'b01, -1);
        clear_got();
        read_txn(4'h2, 32'h20, 0, 3'd2, 2'b01, 2);
        chk("strb_merge", got_d[0], 32'hFF22_FF44);

        // AW and AR in the same cycle
        wdat[0] = 32'hA5A5_0001; wdat[1] = 32'hA5A5_0002;
        wstb[0] = 4'hF; wstb[1] = 4'hF;
        clear_got();
        fork
            write_txn(4'h6, 32'h30, 1, 3'd2, 2'b01, -1);
            read_txn(4'h7, 32'h30, 1, 3'd2, 2'b01, 0);
        join
        chk("aw_before_ar", 64'(ar_hs_time > b_hs_time), 1);
        chk("tie_data0", got_d[0], 32'hA5A5_0001);
        chk("tie_data1", got_d[1], 32'hA5A5_0002);

        // Top of range
        wdat[0] = 32'h1234_5678; wstb[0] = 4'hF;
        write_txn(4'h8, 32'h3FC, 0, 3'd2, 2'b01, -1);
        clear_got();
        read_txn(4'h9, 32'h3FC, 1, 3'd2, 2'b01, 0);
        chk("top_count", got_d.size(), 2);
        chk("top_d0", {got_d[0], got_p[0]}, {32'd0, 2'b10});
        chk("top_d1", {got_d[1], got_p[1], got_l[1]}, {32'd0, 2'b10, 1'b1});
        wdat[0] = 32'hBAD0_0000; wdat[1] = 32'hBAD0_0001;
        write_txn(4'hA, 32'h3FC, 1, 3'd2, 2'b01, -1);
        write_txn(4'hB, 32'h40, 0, 3'd2, 2'b00, -1);
        clear_got();
        read_txn(4'hC, 32'h3FC, 0, 3'd2, 2'b01, 0);
        chk("top_unchanged", got_d[0], 32'h1234_5678);
        read_txn(4'hC, 32'h40, 0, 3'd2, 2'b01, 0);

        // Reset in the middle of a write burst
        for (int i = 0; i < 4; i++) begin wdat[i] = 32'hC0DE_0000 + 32'(i); wstb[i] = 4'hF; end
        write_txn(4'h3, 32'h200, 3, 3'd2, 2'b01, 2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outputs",
            {bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast,
             bus.bid, bus.rid, bus.bresp, bus.rresp, bus.rdata}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_txn(4'h4, 32'h200, 3, 3'd2, 2'b01, 0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            tlen   = $urandom_range(0, 15);
            taddr  = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            tsize  = ($urandom_range(0, 9) == 0) ? 3'd1 : 3'd2;
            tburst = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b01;
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= tlen; i++) begin
                    wdat[i] = $urandom;
                    wstb[i] = 4'($urandom_range(0, 15));
                end
                write_txn(4'($urandom_range(0, 15)), taddr, tlen, tsize, tburst, -1);
            end else begin
                read_txn(4'($urandom_range(0, 15)), taddr, tlen, tsize, tburst,
                         $urandom_range(0, 2));
            end
        end

        repeat (3) @(posedge clk);
        chk("b_queue_drained", exp_b.size(), 0);
        chk("r_queue_drained", exp_r.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning the number of 32-bit words of backing store (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address mapped to word 0.
REQ-003 SHALL provide clk  in  1  sole clock; every AXI channel is synchronous to it.
REQ-004 SHALL provide rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide s_axi_aw{id,addr,len,size,burst,valid} in 4/32/8/3/2/1 and s_axi_awready out 1, forming the write address channel.
REQ-006 SHALL provide s_axi_w{data,strb,last,valid} in 32/4/1/1 and s_axi_wready out 1, forming the write data channel.
REQ-007 SHALL provide s_axi_b{id,resp,valid} out 4/2/1 and s_axi_bready in 1, forming the write response channel.
REQ-008 SHALL provide s_axi_ar{id,addr,len,size,burst,valid} in 4/32/8/3/2/1 and s_axi_arready out 1, forming the read address channel.
REQ-009 SHALL provide s_axi_r{id,data,resp,last,valid} out 4/32/2/1/1 and s_axi_rready in 1, forming the read data channel.

Function
REQ-010 SHALL run one FSM: IDLE, W_DATA, W_RESP, R_FETCH, R_DATA; only one transaction in flight.
REQ-011 SHALL assert awready and arready only in IDLE; when awvalid and arvalid are both high in IDLE, the write is accepted, arready=0 that cycle.
REQ-012 SHALL, on AW handshake, latch id, addr, len, and an error flag, then go to W_DATA.
REQ-013 SHALL set the error flag when burst!=INCR(2'b01), size!=3'd2, or any beat address falls outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS).
REQ-014 SHALL hold wready=1 in W_DATA; each W handshake writes the byte lanes enabled by wstrb at the current word (suppressed if error), then adds 4 to the address.
REQ-015 SHALL count beats and leave W_DATA after len+1 beats regardless of wlast; wlast is ignored.
REQ-016 SHALL, in W_RESP, drive bvalid=1, bid=latched id, bresp=OKAY(00) or SLVERR(10), and hold until bready, then return to IDLE.
REQ-017 SHALL, on AR handshake, latch id, addr, len, and the error flag per REQ-013, then go to R_FETCH.
REQ-018 SHALL, in R_FETCH, issue one SRAM read (1-cycle latency) and enter R_DATA the next cycle; each beat therefore costs at least 2 cycles.
REQ-019 SHALL, in R_DATA, drive rvalid=1, rid=latched id, rdata=SRAM output (0 if error), rresp=OKAY/SLVERR, rlast=1 only on beat len; all are stable until rready.
REQ-020 SHALL, on an R handshake, return to IDLE after the final beat, or otherwise add 4 to the address and return to R_FETCH.
REQ-021 SHALL not wrap the address inside a burst; a burst crossing the top of the range sets the error flag for the whole burst.
REQ-022 SHALL give a read issued after a completed write (B handshake done) the new data; there is no hazard window.

Reset
REQ-023 SHALL, while rst_n=0, force FSM=IDLE, awready=arready=wready=bvalid=rvalid=rlast=0, bid/rid/bresp/rresp/rdata=0, and clear the counters.
REQ-024 SHALL abort any burst on reset mid-operation; memory contents are not cleared, and already written beats persist.

Structure
REQ-025 SHALL take AXI burst/resp encodings (INCR, OKAY, SLVERR) and the FSM state enum from the shared package holy_axi_pkg.
REQ-026 SHALL instantiate one sub-module, sram_1p_bytewe (single port, 32-bit, byte write enables, registered read), for the storage.

Verification
REQ-027 SHALL cover: write len=0 addr 0x10 data 0xDEADBEEF strb 1111, read back -> rdata 0xDEADBEEF, rlast=1, OKAY.
REQ-028 SHALL cover: read burst len=7 at 0x100 after an 8-beat write of 0..7 -> 8 beats 0..7, rlast only on the 8th, rid echoes arid=4'h5.
REQ-029 SHALL cover: rready toggled every other cycle -> no beat lost or duplicated, and rdata held stable while stalled.
REQ-030 SHALL cover: awvalid and arvalid raised in the same cycle -> write completes (B) before arready rises, and the read returns the new data.
REQ-031 SHALL cover: strb=0101 over 0xFFFFFFFF with data 0x11223344 -> readback 0xFF22FF44.
REQ-032 SHALL cover: a read at BASE_ADDR+4*MEM_WORDS-4 with len=1 -> two beats with SLVERR and data 0, and memory is unchanged.
